// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer: consumes rasterizer fragments, clips them to the screen,
// depth-tests against the Z buffer and writes color/depth to the frame and
// Z memories over a shared address. Also runs a full-screen clear sweep.
module pixel_fb_writer #(
  parameter int          FB_WIDTH    = 320,
  parameter int          FB_HEIGHT   = 240,
  parameter int          ADDR_W      = 17,
  parameter logic [15:0] CLEAR_COLOR = 16'h0000,
  parameter logic [1:0]  DEPTH_FAR   = 2'd3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_frag_valid,
  output logic              out_frag_ready,
  input  logic [15:0]       in_pixel_x,
  input  logic [15:0]       in_pixel_y,
  input  logic [1:0]        in_pixel_depth,
  input  logic [15:0]       in_pixel_color,
  input  logic              in_sig_clear,
  output logic              out_sig_clear_busy,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_z_re,
  input  logic [1:0]        in_z_rdata,
  output logic              out_z_we,
  output logic [1:0]        out_z_wdata,
  output logic              out_fb_we,
  output logic [15:0]       out_fb_wdata,
  output logic [15:0]       out_pix_written,
  output logic [15:0]       out_pix_rejected
);

  localparam logic [31:0]       WIDTH_U   = 32'(FB_WIDTH);
  localparam logic [31:0]       HEIGHT_U  = 32'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ZREAD = 3'd1,
    ZCMP  = 3'd2,
    WRITE = 3'd3,
    CLEAR = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic               clear_pending;
  logic [ADDR_W-1:0]  addr;
  logic [1:0]         frag_depth;
  logic [15:0]        frag_color;
  logic [15:0]        written, rejected;

  logic               accept, in_range, rej_inc, wr_inc, clear_start;
  logic [31:0]        frag_addr_full;
  logic [ADDR_W-1:0]  frag_addr;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_range       = ({16'd0, in_pixel_x} < WIDTH_U) && ({16'd0, in_pixel_y} < HEIGHT_U);
  assign frag_addr_full = {16'd0, in_pixel_y} * WIDTH_U + {16'd0, in_pixel_x};
  assign frag_addr      = frag_addr_full[ADDR_W-1:0];

  // A pending or fresh clear blocks fragment acceptance in IDLE.
  assign out_frag_ready = (state == IDLE) & ~in_sig_clear & ~clear_pending;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    rej_inc     = 1'b0;
    wr_inc      = 1'b0;
    clear_start = 1'b0;
    case (state)
      IDLE: begin
        if (clear_pending || in_sig_clear) begin
          state_nxt   = CLEAR;
          clear_start = 1'b1;
        end else if (in_frag_valid) begin
          accept = 1'b1;
          if (in_range) state_nxt = ZREAD;
          else          rej_inc   = 1'b1;
        end
      end
      ZREAD: state_nxt = ZCMP;
      ZCMP: begin
        if (frag_depth < in_z_rdata) begin
          state_nxt = WRITE;
        end else begin
          rej_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        wr_inc    = 1'b1;
        state_nxt = IDLE;
      end
      CLEAR: if (addr == LAST_ADDR) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Clear request latched while a fragment is in flight; dropped when the sweep ends.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                     clear_pending <= 1'b0;
    else if (state == CLEAR && state_nxt == IDLE)     clear_pending <= 1'b0;
    else if (in_sig_clear && state != IDLE && state != CLEAR) clear_pending <= 1'b1;
  end

  // Shared address: fragment address on accept, sweep counter during CLEAR.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                addr <= '0;
    else if (clear_start)                        addr <= '0;
    else if (accept && in_range)                 addr <= frag_addr;
    else if (state == CLEAR && addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
  end

  // Fragment payload captured on the accepting edge only.
  always_ff @(posedge clock) begin
    if (accept) begin
      frag_depth <= in_pixel_depth;
      frag_color <= in_pixel_color;
    end
  end

  // Written / rejected statistics, zeroed when a clear sweep begins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      written  <= 16'd0;
      rejected <= 16'd0;
    end else if (clear_start) begin
      written  <= 16'd0;
      rejected <= 16'd0;
    end else begin
      if (rej_inc) rejected <= sat_inc(rejected);
      if (wr_inc)  written  <= sat_inc(written);
    end
  end

  // Memory-side outputs decode only the registered state, so reset kills them at once.
  assign out_z_re           = (state == ZREAD);
  assign out_fb_we          = (state == WRITE) || (state == CLEAR);
  assign out_z_we           = out_fb_we;
  assign out_mem_addr       = (state == IDLE) ? '0 : addr;
  assign out_fb_wdata       = (state == WRITE) ? frag_color :
                              (state == CLEAR) ? CLEAR_COLOR : 16'd0;
  assign out_z_wdata        = (state == WRITE) ? frag_depth :
                              (state == CLEAR) ? DEPTH_FAR : 2'd0;
  assign out_sig_clear_busy = (state == CLEAR);
  assign out_pix_written    = written;
  assign out_pix_rejected   = rejected;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb_pixel_fb_writer: scoreboard bench with a behavioural Z-buffer model and
// a behavioural memory attached to the DUT's memory port.
`timescale 1ns/1ps
module tb_pixel_fb_writer;

  localparam int W = 320;
  localparam int H = 240;
  localparam int NPIX = W * H;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_frag_valid;
  logic        out_frag_ready;
  logic [15:0] in_pixel_x, in_pixel_y, in_pixel_color;
  logic [1:0]  in_pixel_depth;
  logic        in_sig_clear;
  logic        out_sig_clear_busy;
  logic [16:0] out_mem_addr;
  logic        out_z_re, out_z_we, out_fb_we;
  logic [1:0]  in_z_rdata, out_z_wdata;
  logic [15:0] out_fb_wdata, out_pix_written, out_pix_rejected;

  pixel_fb_writer dut (
    .clock(clock), .reset_n(reset_n),
    .in_frag_valid(in_frag_valid), .out_frag_ready(out_frag_ready),
    .in_pixel_x(in_pixel_x), .in_pixel_y(in_pixel_y),
    .in_pixel_depth(in_pixel_depth), .in_pixel_color(in_pixel_color),
    .in_sig_clear(in_sig_clear), .out_sig_clear_busy(out_sig_clear_busy),
    .out_mem_addr(out_mem_addr), .out_z_re(out_z_re), .in_z_rdata(in_z_rdata),
    .out_z_we(out_z_we), .out_z_wdata(out_z_wdata),
    .out_fb_we(out_fb_we), .out_fb_wdata(out_fb_wdata),
    .out_pix_written(out_pix_written), .out_pix_rejected(out_pix_rejected)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int clr_idx = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural Z memory: synchronous read, read-before-write, starts all far.
  logic [1:0] zmem [0:NPIX-1];
  bit mem_init = 1'b0;
  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < NPIX; i++) zmem[i] = 2'd3;
      mem_init = 1'b1;
    end
    if (out_z_re && int'(out_mem_addr) < NPIX) in_z_rdata <= zmem[int'(out_mem_addr)];
    if (out_z_we && int'(out_mem_addr) < NPIX) zmem[int'(out_mem_addr)] = out_z_wdata;
  end

  // Reference model state.
  typedef struct { logic [16:0] a; logic [15:0] c; logic [1:0] d; } wr_t;
  wr_t sb[$];
  logic [1:0] exp_z [0:NPIX-1];
  int exp_wr = 0;
  int exp_rej = 0;

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of one accepted fragment: clip, then strict depth test against the model Z buffer.
  task automatic model_accept(input int x, input int y, input logic [1:0] d, input logic [15:0] c);
    int a;
    wr_t e;
    if (x >= W || y >= H) begin
      exp_rej = sat(exp_rej);
    end else begin
      a = y * W + x;
      if (d < exp_z[a]) begin
        e.a = 17'(a); e.c = c; e.d = d;
        sb.push_back(e);
        exp_z[a] = d;
        exp_wr = sat(exp_wr);
      end else begin
        exp_rej = sat(exp_rej);
      end
    end
  endtask

  task automatic send_frag(input int x, input int y, input logic [1:0] d, input logic [15:0] c);
    int n = 0;
    @(negedge clock);
    while (!out_frag_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!out_frag_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: ready=%0d after %0d cycles", out_frag_ready, n);
    end else begin
      in_frag_valid  = 1'b1;
      in_pixel_x     = 16'(x);
      in_pixel_y     = 16'(y);
      in_pixel_depth = d;
      in_pixel_color = c;
      @(posedge clock);
      #1;
      in_frag_valid  = 1'b0;
      in_pixel_x     = 16'($urandom);
      in_pixel_y     = 16'($urandom);
      in_pixel_depth = 2'($urandom);
      in_pixel_color = 16'($urandom);
      model_accept(x, y, d, c);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_written"},  32'(out_pix_written),  32'(exp_wr));
    check({tag, "_rejected"}, 32'(out_pix_rejected), 32'(exp_rej));
  endtask

  // Monitor: every write strobe is either a clear-sweep step or a scoreboard entry.
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_sig_clear_busy) begin
        total++;
        if (!(out_fb_we && out_z_we && int'(out_mem_addr) == clr_idx &&
              out_fb_wdata == 16'h0000 && out_z_wdata == 2'd3)) begin
          bad++;
          $display("FAIL clear_step: we=%0d/%0d addr=%0d data=%0h/%0d expected addr=%0d data=0/3",
                   out_fb_we, out_z_we, out_mem_addr, out_fb_wdata, out_z_wdata, clr_idx);
        end
        clr_idx++;
      end else if (out_fb_we || out_z_we) begin
        wr_t e;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr=%0d color=%0h depth=%0d expected no write",
                   out_mem_addr, out_fb_wdata, out_z_wdata);
        end else begin
          e = sb.pop_front();
          if (!(out_fb_we && out_z_we && out_mem_addr == e.a &&
                out_fb_wdata == e.c && out_z_wdata == e.d)) begin
            bad++;
            $display("FAIL frag_write: we=%0d/%0d addr=%0d color=%0h depth=%0d expected addr=%0d color=%0h depth=%0d",
                     out_fb_we, out_z_we, out_mem_addr, out_fb_wdata, out_z_wdata, e.a, e.c, e.d);
          end
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t[4];
    int n, bc, x, y;
    logic [15:0] c;
    logic [1:0] d;

    for (int i = 0; i < NPIX; i++) exp_z[i] = 2'd3;
    reset_n = 1'b0; in_frag_valid = 1'b0; in_sig_clear = 1'b0;
    in_pixel_x = '0; in_pixel_y = '0; in_pixel_depth = '0; in_pixel_color = '0;
    repeat (3) @(negedge clock);
    check("rst_ready",  32'(out_frag_ready), 32'd1);
    check("rst_zre",    32'(out_z_re), 32'd0);
    check("rst_we",     32'({out_fb_we, out_z_we}), 32'd0);
    check("rst_busy",   32'(out_sig_clear_busy), 32'd0);
    check("rst_addr",   32'(out_mem_addr), 32'd0);
    check("rst_wdata",  32'({out_fb_wdata, out_z_wdata}), 32'd0);
    check_counters("rst");
    reset_n = 1'b1;

    // Basic passing fragment.
    send_frag(3, 2, 2'd1, 16'hF800);
    @(negedge clock);
    check("t1_zre",  32'(out_z_re), 32'd1);
    check("t1_addr", 32'(out_mem_addr), 32'd643);
    check("t1_no_we_in_zread", 32'(out_fb_we), 32'd0);
    repeat (3) @(negedge clock);
    check_counters("t1");

    // Equal and farther depth both fail.
    send_frag(3, 2, 2'd1, 16'h1234);
    send_frag(3, 2, 2'd2, 16'h5678);
    repeat (3) @(negedge clock);
    check_counters("t2");
    check("t2_ready", 32'(out_frag_ready), 32'd1);

    // Off-screen fragments: no memory access, ready again next cycle.
    send_frag(320, 0, 2'd0, 16'hAAAA);
    @(negedge clock);
    check("t3a_ready", 32'(out_frag_ready), 32'd1);
    check("t3a_zre",   32'(out_z_re), 32'd0);
    send_frag(0, 240, 2'd0, 16'hBBBB);
    @(negedge clock);
    check("t3b_ready", 32'(out_frag_ready), 32'd1);
    check("t3b_zre",   32'(out_z_re), 32'd0);
    check_counters("t3");

    // Random fragments over a small window so depths collide.
    for (int i = 0; i < 60; i++) begin
      x = $urandom_range(0, 12);
      y = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) x = W + $urandom_range(0, 40);
      if ($urandom_range(0, 9) == 0) y = H + $urandom_range(0, 40);
      send_frag(x, y, 2'($urandom), 16'($urandom));
    end
    repeat (4) @(negedge clock);
    check_counters("t4");

    // Back-to-back stream with valid held high.
    n = 0;
    @(negedge clock);
    in_pixel_x = 16'd10; in_pixel_y = 16'd100; in_pixel_depth = 2'd0; in_pixel_color = 16'h0101;
    in_frag_valid = 1'b1;
    for (int k = 0; k < 60 && n < 4; k++) begin
      if (out_frag_ready) begin
        t[n] = cyc;
        model_accept(int'(in_pixel_x), int'(in_pixel_y), in_pixel_depth, in_pixel_color);
        n++;
        @(posedge clock);
        #1;
        if (n < 4) begin
          in_pixel_x = 16'(10 + 3 * n);
          in_pixel_color = 16'($urandom);
        end else begin
          in_frag_valid = 1'b0;
        end
      end
      @(negedge clock);
    end
    check("t5_accepts", 32'(n), 32'd4);
    for (int i = 0; i < 3; i++) check("t5_spacing", 32'(t[i+1] - t[i]), 32'd4);
    repeat (4) @(negedge clock);
    check_counters("t5");

    // Clear request while a passing fragment is in ZCMP.
    send_frag(50, 50, 2'd0, 16'hC0DE);
    @(posedge clock); #1;
    in_sig_clear = 1'b1;
    @(posedge clock); #1;
    in_sig_clear = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("t6_ready_pending", 32'(out_frag_ready), 32'd0);
    check("t6_busy_not_yet",  32'(out_sig_clear_busy), 32'd0);
    clr_idx = 0;
    bc = 0;
    for (int k = 0; k < 80000; k++) begin
      @(negedge clock);
      if (out_sig_clear_busy) bc++;
      else if (bc > 0) break;
    end
    check("t6_busy_cycles", 32'(bc), 32'(NPIX));
    check("t6_clear_steps", 32'(clr_idx), 32'(NPIX));
    exp_wr = 0; exp_rej = 0;
    for (int i = 0; i < NPIX; i++) exp_z[i] = 2'd3;
    check_counters("t6");
    check("t6_ready_after", 32'(out_frag_ready), 32'd1);

    // Clear with a simultaneous valid fragment, then reset mid-sweep.
    @(negedge clock);
    in_frag_valid = 1'b1; in_pixel_x = 16'd5; in_pixel_y = 16'd5; in_pixel_depth = 2'd0;
    in_sig_clear = 1'b1;
    clr_idx = 0;
    #1;
    check("t7_ready_blocked", 32'(out_frag_ready), 32'd0);
    @(posedge clock); #1;
    in_sig_clear = 1'b0; in_frag_valid = 1'b0;
    @(negedge clock);
    check("t7_busy", 32'(out_sig_clear_busy), 32'd1);
    repeat (300) @(negedge clock);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("t7_rst_we",   32'({out_fb_we, out_z_we}), 32'd0);
    check("t7_rst_busy", 32'(out_sig_clear_busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("t7_ready_after", 32'(out_frag_ready), 32'd1);
    check_counters("t7");

    // Reset during WRITE of a second passing fragment.
    d = 2'd0; c = 16'h7777;
    send_frag(7, 9, d, c);
    repeat (4) @(negedge clock);
    send_frag(8, 9, d, c);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("t8_write_strobe", 32'(out_fb_we), 32'd1);
    check("t8_written_pre",  32'(out_pix_written), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t8_rst_we", 32'({out_fb_we, out_z_we}), 32'd0);
    void'(sb.pop_back());
    exp_wr = 0; exp_rej = 0;
    check_counters("t8");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("t8_ready", 32'(out_frag_ready), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
